oled_fb_streamer: RTL and testbench

Single-clock reader that streams the camera frame buffer into the OLED pixel driver. It walks screen coordinates in lockstep with the driver's next_pixel strobe and maps each screen pixel to a frame-buffer address, with integer upscaling and a border outside the image window. It issues reads against a synchronous-read RAM port of configurable latency and converts RGB444 pixels to RGB565 or RGB332.

---
 rtl/ov7670_pkg.sv | 39 +++
 rtl/fb_color_conv.sv | 41 ++++
 rtl/oled_fb_streamer.sv | 186 ++++++++++++++++++
 tb/tb_oled_fb_streamer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// Shared pixel-format constants, streamer state encoding and RGB444 conversion helpers
// for the camera-to-OLED path.
package ov7670_pkg;

    localparam int c_nb_r      = 4;
    localparam int c_nb_g      = 4;
    localparam int c_nb_b      = 4;
    localparam int c_nb_rgb444 = c_nb_r + c_nb_g + c_nb_b;

    localparam int c_fmt_565 = 16;
    localparam int c_fmt_332 = 8;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        READY
    } fb_state_t;

    function automatic logic [15:0] rgb444_to_565(input logic [c_nb_rgb444-1:0] p);
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        r = p[11:8];
        g = p[7:4];
        b = p[3:0];
        return {r, r[3], g, g[3:2], b, b[3]};
    endfunction

    function automatic logic [7:0] rgb444_to_332(input logic [c_nb_rgb444-1:0] p);
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        r = p[11:8];
        g = p[7:4];
        b = p[3:0];
        return {r[3:1], g[3:1], b[3:2]};
    endfunction

endpackage

// File: rtl/fb_color_conv.sv
// Registered red/blue swap and RGB444 -> RGB565/RGB332 conversion; a direct colour
// (border or test pattern) can be loaded instead of frame-buffer data.
module fb_color_conv
    import ov7670_pkg::*;
#(
    parameter int c_color_bits = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_fb,
    input  logic [c_nb_rgb444-1:0]  fb_pxl,
    input  logic                    swap_r_b,
    input  logic                    load_direct,
    input  logic [c_color_bits-1:0] direct_color,
    output logic [c_color_bits-1:0] color
);

    logic [c_nb_rgb444-1:0]  pxl_sw;
    logic [c_color_bits-1:0] conv;

    assign pxl_sw = swap_r_b ? {fb_pxl[3:0], fb_pxl[7:4], fb_pxl[11:8]} : fb_pxl;

    generate
        if (c_color_bits == c_fmt_565) begin : g_565
            assign conv = rgb444_to_565(pxl_sw);
        end else begin : g_332
            assign conv = rgb444_to_332(pxl_sw);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color <= '0;
        end else if (load_fb) begin
            color <= conv;
        end else if (load_direct) begin
            color <= direct_color;
        end
    end

endmodule

// File: rtl/oled_fb_streamer.sv
// Streams the camera frame buffer to the OLED driver with integer upscaling and a border.
// Optional checkerboard test pattern is built only when OLED_TESTPAT_EN is defined.
module oled_fb_streamer
    import ov7670_pkg::*;
#(
    parameter int c_img_cols     = 80,
    parameter int c_img_rows     = 60,
    parameter int c_nb_img_pxls  = 13,
    parameter int c_nb_buf_red   = 4,
    parameter int c_nb_buf_green = 4,
    parameter int c_nb_buf_blue  = 4,
    parameter int c_x_size       = 128,
    parameter int c_y_size       = 128,
    parameter int c_nb_xy        = 7,
    parameter int c_scale        = 1,
    parameter int c_color_bits   = 16,
    parameter int c_rd_lat       = 1,
    parameter logic [c_color_bits-1:0] c_border = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     frame_restart,
    input  logic                     swap_r_b,
    input  logic                     testmode,
    input  logic                     next_pixel,
    output logic                     fb_rd_en,
    output logic [c_nb_img_pxls-1:0] fb_addr,
    input  logic [c_nb_buf_red+c_nb_buf_green+c_nb_buf_blue-1:0] fb_pxl,
    output logic [c_color_bits-1:0]  color,
    output logic                     color_valid,
    output logic [c_nb_xy-1:0]       scr_x,
    output logic [c_nb_xy-1:0]       scr_y,
    output logic                     frame_done,
    output logic                     underrun
);

    localparam int         c_win_x   = c_img_cols * c_scale;
    localparam int         c_win_y   = c_img_rows * c_scale;
    localparam logic [1:0] c_sub_max = 2'(c_scale - 1);

    fb_state_t                 state;
    logic [c_nb_xy-1:0]        img_col;
    logic [1:0]                sub_x;
    logic [1:0]                sub_y;
    logic [c_nb_img_pxls-1:0]  row_base;
    logic                      issued;
    logic [c_rd_lat-1:0]       rd_vld_p;
    logic [c_rd_lat-1:0]       rd_vld_next;
    logic                      in_win;
    logic                      use_fb;
    logic                      go;
    logic                      clear_pos;
    logic                      load_fb;
    logic                      load_direct;
    logic [c_color_bits-1:0]   direct_color;

    assign in_win = (int'(scr_x) < c_win_x) && (int'(scr_y) < c_win_y);

`ifdef OLED_TESTPAT_EN
    assign use_fb       = in_win && !testmode;
    assign direct_color = (in_win && testmode) ? {c_color_bits{scr_x[3] ^ scr_y[3]}} : c_border;
`else
    logic unused_testmode;
    assign unused_testmode = testmode;
    assign use_fb          = in_win;
    assign direct_color    = c_border;
`endif

    // Any enable drop, restart or pixel consumption abandons the current fetch.
    assign go          = enable && !frame_restart && !next_pixel;
    assign clear_pos   = !enable || frame_restart;
    assign fb_rd_en    = go && (state == FETCH) && !issued && use_fb;
    assign load_fb     = go && (state == FETCH) && issued && rd_vld_p[c_rd_lat-1];
    assign load_direct = go && (state == FETCH) && !issued && !use_fb;
    assign fb_addr     = row_base + c_nb_img_pxls'(img_col);

    generate
        if (c_rd_lat == 1) begin : g_lat1
            assign rd_vld_next = fb_rd_en;
        end else begin : g_latn
            assign rd_vld_next = {rd_vld_p[c_rd_lat-2:0], fb_rd_en};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            issued      <= 1'b0;
            rd_vld_p    <= '0;
            color_valid <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            rd_vld_p <= rd_vld_next;
            if (!enable || frame_restart || next_pixel) begin
                state       <= enable ? FETCH : IDLE;
                issued      <= 1'b0;
                rd_vld_p    <= '0;
                color_valid <= 1'b0;
                if (enable && frame_restart) begin
                    underrun <= 1'b0;
                end else if (enable && state != READY) begin
                    underrun <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: state <= FETCH;
                    FETCH: begin
                        if (fb_rd_en) begin
                            issued <= 1'b1;
                        end else if (load_fb || load_direct) begin
                            color_valid <= 1'b1;
                            state       <= READY;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Screen walk and frame-buffer address stepping; upscaling by counting sub-pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scr_x      <= '0;
            scr_y      <= '0;
            img_col    <= '0;
            sub_x      <= '0;
            sub_y      <= '0;
            row_base   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (clear_pos) begin
                scr_x    <= '0;
                scr_y    <= '0;
                img_col  <= '0;
                sub_x    <= '0;
                sub_y    <= '0;
                row_base <= '0;
            end else if (next_pixel) begin
                if (scr_x == c_nb_xy'(c_x_size - 1)) begin
                    scr_x   <= '0;
                    img_col <= '0;
                    sub_x   <= '0;
                    if (scr_y == c_nb_xy'(c_y_size - 1)) begin
                        scr_y      <= '0;
                        sub_y      <= '0;
                        row_base   <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        scr_y <= scr_y + 1'b1;
                        if (sub_y == c_sub_max) begin
                            sub_y    <= '0;
                            row_base <= row_base + c_nb_img_pxls'(c_img_cols);
                        end else begin
                            sub_y <= sub_y + 1'b1;
                        end
                    end
                end else begin
                    scr_x <= scr_x + 1'b1;
                    if (sub_x == c_sub_max) begin
                        sub_x   <= '0;
                        img_col <= img_col + 1'b1;
                    end else begin
                        sub_x <= sub_x + 1'b1;
                    end
                end
            end
        end
    end

    fb_color_conv #(
        .c_color_bits (c_color_bits)
    ) u_conv (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_fb      (load_fb),
        .fb_pxl       (fb_pxl),
        .swap_r_b     (swap_r_b),
        .load_direct  (load_direct),
        .direct_color (direct_color),
        .color        (color)
    );

endmodule

// File: tb/tb_oled_fb_streamer.sv
// Bench for oled_fb_streamer: two instances (scale 1 / latency 1 / RGB565 and
// scale 2 / latency 3 / RGB332) share stimulus and are checked against a pixel-level model.
module tb_oled_fb_streamer;

    localparam int S1 = 1, L1 = 1;
    localparam int S2 = 2, L2 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, enable, frame_restart, swap_r_b, testmode, next_pixel;
    logic        fb_rd_en1, fb_rd_en2;
    logic [12:0] fb_addr1, fb_addr2;
    logic [11:0] fb_pxl1, fb_pxl2;
    logic [15:0] color1;
    logic [7:0]  color2;
    logic        cv1, cv2, fd1, fd2, ur1, ur2;
    logic [6:0]  sx1, sy1, sx2, sy2;

    oled_fb_streamer #(.c_scale(S1), .c_rd_lat(L1), .c_color_bits(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .frame_restart(frame_restart),
        .swap_r_b(swap_r_b), .testmode(testmode), .next_pixel(next_pixel),
        .fb_rd_en(fb_rd_en1), .fb_addr(fb_addr1), .fb_pxl(fb_pxl1), .color(color1),
        .color_valid(cv1), .scr_x(sx1), .scr_y(sy1), .frame_done(fd1), .underrun(ur1));

    oled_fb_streamer #(.c_scale(S2), .c_rd_lat(L2), .c_color_bits(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .frame_restart(frame_restart),
        .swap_r_b(swap_r_b), .testmode(testmode), .next_pixel(next_pixel),
        .fb_rd_en(fb_rd_en2), .fb_addr(fb_addr2), .fb_pxl(fb_pxl2), .color(color2),
        .color_valid(cv2), .scr_x(sx2), .scr_y(sy2), .frame_done(fd2), .underrun(ur2));

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    bit fb_force = 1'b0;

    function automatic int fb_data(input int a);
        return fb_force ? 'hF84 : (a & 'hFFF);
    endfunction

    // Frame-buffer RAM models: requests sampled mid-cycle, returned c_rd_lat clocks later.
    bit req_v[2];
    int req_a[2];
    bit pv[2][4];
    int pa[2][4];

    always @(negedge clk) begin
        #3;
        req_v[0] = fb_rd_en1; req_a[0] = int'(fb_addr1);
        req_v[1] = fb_rd_en2; req_a[1] = int'(fb_addr2);
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            for (int i = 3; i > 0; i--) begin
                pv[k][i] = pv[k][i-1];
                pa[k][i] = pa[k][i-1];
            end
            pv[k][0] = req_v[k];
            pa[k][0] = req_a[k];
        end
        fb_pxl1 <= pv[0][L1-1] ? 12'(fb_data(pa[0][L1-1])) : 12'($urandom);
        fb_pxl2 <= pv[1][L2-1] ? 12'(fb_data(pa[1][L2-1])) : 12'($urandom);
    end

    // Behavioural model: screen position, cycles since the current fetch began, sticky underrun.
    int mx = 0, my = 0, mcnt = 0;
    bit midle = 1'b1, mfd = 1'b0;
    bit mur[2];

    function automatic int sc(input int k);  return (k == 0) ? S1 : S2; endfunction
    function automatic int lat(input int k); return (k == 0) ? L1 : L2; endfunction
    function automatic bit inwin(input int k, input int x, input int y);
        return (x < 80 * sc(k)) && (y < 60 * sc(k));
    endfunction
    function automatic int need(input int k);
        return inwin(k, mx, my) ? lat(k) + 1 : 1;
    endfunction
    function automatic int exp_addr(input int k, input int x, input int y);
        return (y / sc(k)) * 80 + x / sc(k);
    endfunction
    function automatic int conv(input int k, input int p, input bit sw);
        int r, g, b, t;
        r = (p >> 8) & 15; g = (p >> 4) & 15; b = p & 15;
        if (sw) begin t = r; r = b; b = t; end
        if (k == 0) return (r * 2 + r / 8) * 2048 + (g * 4 + g / 4) * 32 + (b * 2 + b / 8);
        return (r / 2) * 32 + (g / 2) * 4 + b / 4;
    endfunction
    function automatic int exp_color(input int k);
        return inwin(k, mx, my) ? conv(k, fb_data(exp_addr(k, mx, my)), swap_r_b) : 0;
    endfunction

    int lit[2][4][3] = '{'{'{0, 0, 0},  '{79, 0, 79}, '{0, 1, 80}, '{79, 59, 4799}},
                         '{'{1, 1, 0},  '{2, 0, 1},   '{0, 2, 80}, '{127, 119, 4783}}};

    task automatic cmp(input int k, input bit ren, input int addr, input bit cv, input int col,
                       input int sx, input int sy, input bit fd, input bit ur);
        bit eren, ev;
        eren = rst_n && enable && !frame_restart && !next_pixel && !midle && mcnt == 0 && inwin(k, mx, my);
        ev   = rst_n && !midle && mcnt >= need(k);
        check($sformatf("d%0d_rd_en", k), ren, eren);
        if (eren) check($sformatf("d%0d_addr", k), addr, exp_addr(k, mx, my));
        check($sformatf("d%0d_valid", k), cv, ev);
        if (ev) check($sformatf("d%0d_color", k), col, exp_color(k));
        check($sformatf("d%0d_x", k), sx, mx);
        check($sformatf("d%0d_y", k), sy, my);
        check($sformatf("d%0d_frame_done", k), fd, mfd);
        check($sformatf("d%0d_underrun", k), ur, mur[k]);
        if (ren) begin
            for (int i = 0; i < 4; i++)
                if (sx == lit[k][i][0] && sy == lit[k][i][1])
                    check($sformatf("d%0d_lit_addr_%0d_%0d", k, sx, sy), addr, lit[k][i][2]);
        end
        if (cv && sx == 0 && sy == ((k == 0) ? 60 : 120))
            check($sformatf("d%0d_lit_border", k), col, 0);
        if (k == 0 && sx == 80 && sy == 0)
            check("d0_lit_no_rd_80", ren, 0);
    endtask

    always begin
        @(posedge clk);
        if (!rst_n) begin
            mx = 0; my = 0; midle = 1; mcnt = 0; mfd = 0; mur[0] = 0; mur[1] = 0;
        end else if (!enable) begin
            midle = 1; mx = 0; my = 0; mfd = 0;
        end else if (frame_restart) begin
            mx = 0; my = 0; midle = 0; mcnt = 0; mfd = 0; mur[0] = 0; mur[1] = 0;
        end else if (next_pixel) begin
            for (int k = 0; k < 2; k++)
                if (midle || mcnt < need(k)) mur[k] = 1;
            mfd = 0;
            mx++;
            if (mx == 128) begin
                mx = 0; my++;
                if (my == 128) begin my = 0; mfd = 1; end
            end
            midle = 0; mcnt = 0;
        end else begin
            mfd = 0;
            if (midle) begin midle = 0; mcnt = 0; end
            else if (mcnt < 50) mcnt++;
        end
        #1;
        cmp(0, fb_rd_en1, int'(fb_addr1), cv1, int'(color1), int'(sx1), int'(sy1), fd1, ur1);
        cmp(1, fb_rd_en2, int'(fb_addr2), cv2, int'(color2), int'(sx2), int'(sy2), fd2, ur2);
    end

    function automatic bit slow_row(input int y);
        return y <= 2 || (y >= 59 && y <= 61) || (y >= 119 && y <= 121) || y == 127;
    endfunction

    int fd_cnt, fd_idx;

    initial begin
        rst_n = 0; enable = 0; frame_restart = 0; swap_r_b = 0; testmode = 0; next_pixel = 0;
        repeat (3) @(negedge clk);
        check("rst_color1", color1, 0);   check("rst_valid1", cv1, 0);
        check("rst_rd_en1", fb_rd_en1, 0); check("rst_x1", sx1, 0);
        check("rst_underrun2", ur2, 0);   check("rst_frame_done2", fd2, 0);
        rst_n = 1;
        repeat (3) @(negedge clk);

        // Colour conversion of a known pixel, plain and swapped.
        fb_force = 1; enable = 1;
        repeat (8) @(negedge clk);
        check("lit_565", color1, 16'hFC48);
        check("lit_332", color2, 8'hF1);
        check("lit_valid1", cv1, 1);
        enable = 0;
        @(negedge clk);
        swap_r_b = 1; enable = 1;
        repeat (8) @(negedge clk);
        check("lit_565_swap", color1, 16'h445F);
        enable = 0;
        @(negedge clk);
        fb_force = 0; swap_r_b = 0; enable = 1;
        repeat (8) @(negedge clk);

        // Back-to-back next_pixel underruns, then restart clears it.
        next_pixel = 1;
        @(negedge clk); @(negedge clk);
        next_pixel = 0;
        check("lit_underrun_set", ur1, 1);
        check("lit_underrun_x", sx1, 2);
        frame_restart = 1;
        @(negedge clk);
        frame_restart = 0;
        check("lit_restart_underrun", ur1, 0);
        check("lit_restart_x", sx1, 0);
        check("lit_restart_y", sy1, 0);
        repeat (3) begin
            repeat (4) @(negedge clk);
            next_pixel = 1; @(negedge clk); next_pixel = 0;
        end
        check("lit_adv_x", sx2, 3);
        frame_restart = 1; next_pixel = 1;
        @(negedge clk);
        frame_restart = 0; next_pixel = 0;
        check("lit_restart_np_x", sx1, 0);
        check("lit_restart_np_y", sy1, 0);

        // One full frame at randomized pixel rates.
        fd_cnt = 0; fd_idx = -1;
        for (int p = 0; p < 16384; p++) begin
            int g;
            g = slow_row(p / 128) ? int'($urandom_range(2, 7)) : int'($urandom_range(1, 3));
            repeat (g - 1) @(negedge clk);
            next_pixel = 1;
            @(negedge clk);
            next_pixel = 0;
            if (fd1) begin fd_cnt++; fd_idx = p; end
        end
        check("lit_frame_done_count", fd_cnt, 1);
        check("lit_frame_done_index", fd_idx, 16383);

        // Reset while a latency-3 read is in flight.
        repeat (8) @(negedge clk);
        next_pixel = 1; @(negedge clk); next_pixel = 0;
        @(negedge clk);
        rst_n = 0; enable = 0;
        #1;
        check("lit_arst_color2", color2, 0); check("lit_arst_valid2", cv2, 0);
        check("lit_arst_x2", sx2, 0);        check("lit_arst_color1", color1, 0);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("lit_stale_color2", color2, 0);
            check("lit_stale_valid2", cv2, 0);
        end
        enable = 1;
        repeat (12) @(negedge clk);
        enable = 0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
